// File: rtl/counter_load_seq.sv
// Parallel-load sequencer for the 4-bit up_counter: buffers presets, pulses load,
// verifies the captured value, retries on mismatch and reports abandoned loads.
module counter_load_seq #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 2,
   parameter int GAP_CYC   = 2,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [WIDTH-1:0] req_data,
   output logic             req_ready,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] d_out,
   output logic             load,
   output logic             done,
   output logic             err,
   output logic [7:0]       err_count,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   // Handshake: a preset transfers on the posedge where req_valid && req_ready;
   // req_valid may be held or dropped freely, req_ready is a registered !full.

   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW       = $clog2(DEPTH + 1);
   localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_VERIFY = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic [RW-1:0]    retry_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             push;
   logic             pop;
   logic             in_verify;
   logic             match;
   logic             retry_left;

   assign push       = req_valid && req_ready;
   assign pop        = done || err;
   assign in_verify  = (state == S_VERIFY);
   assign match      = (cnt_in == d_out);
   assign retry_left = (retry_cnt != RW'(MAX_RETRY));

   // Verdicts are decoded in the VERIFY cycle itself so they coincide with the
   // counter value they judge; every term is a flop except the cnt_in compare.
   assign done = in_verify && match;
   assign err  = in_verify && !match && !retry_left;

   assign busy      = (state != S_IDLE) || (count != '0);
   assign dbg_state = state;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + CW'(1);
      else if (!push && pop)
         count_next = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= req_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count     <= count_next;
         req_ready <= (count_next != CW'(DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         d_out     <= '0;
         load      <= 1'b0;
         retry_cnt <= '0;
         gap_cnt   <= '0;
         err_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  d_out <= mem[rd_ptr];
                  load  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               load  <= 1'b0;
               state <= S_VERIFY;
            end
            S_VERIFY: begin
               if (match) begin
                  retry_cnt <= '0;
                  gap_cnt   <= '0;
                  state     <= S_GAP;
               end else if (retry_left) begin
                  // Re-pulse the same d_out; LOAD already guarantees a low cycle between pulses.
                  retry_cnt <= retry_cnt + RW'(1);
                  load      <= 1'b1;
                  state     <= S_LOAD;
               end else begin
                  retry_cnt <= '0;
                  gap_cnt   <= '0;
                  state     <= S_GAP;
                  if (err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
               end
            end
            S_GAP: begin
               if (gap_cnt == GW'(GAP_LAST))
                  state <= S_IDLE;
               else
                  gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_load_seq.sv
// Bench for counter_load_seq: a counter model that can be told to botch loads,
// a transaction-level scoreboard and directed plus random preset traffic.
module tb_counter_load_seq;

   localparam int WIDTH     = 4;
   localparam int DEPTH     = 2;
   localparam int GAP_CYC   = 2;
   localparam int MAX_RETRY = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic [WIDTH-1:0] req_data = '0;
   logic             req_ready;
   logic [WIDTH-1:0] cnt_in = '0;
   logic [WIDTH-1:0] d_out;
   logic             load;
   logic             done;
   logic             err;
   logic [7:0]       err_count;
   logic             busy;
   logic [1:0]       dbg_state;

   counter_load_seq #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .cnt_in(cnt_in), .d_out(d_out), .load(load),
      .done(done), .err(err), .err_count(err_count), .busy(busy),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [WIDTH-1:0] exp_q[$];      // preset expected at the head of the FIFO
   bit               exp_err_q[$];  // outcome: 1 = abandoned
   int               exp_loads_q[$];
   int               fault_q[$];    // loads the counter will still botch, per preset
   int               load_t_q[$];
   int               err_model = 0;
   int               n_loads = 0;
   int               n_vec = 0;
   int               n_miss = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
   endtask

   // ---------------- counter model ----------------
   // A botched load latches a value guaranteed to differ from d_in.
   always @(posedge clk) begin
      if (rst && load) begin
         if (fault_q.size() > 0 && fault_q[0] > 0) begin
            fault_q[0] = fault_q[0] - 1;
            cnt_in <= d_out ^ WIDTH'(1);
         end else begin
            cnt_in <= d_out;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         chk("req_ready", int'(req_ready), int'(exp_q.size() < DEPTH));
         chk("err_count", int'(err_count), err_model);
         if (load) begin
            if (n_loads == 0)
               load_t_q.push_back(cyc);
            n_loads++;
            if (exp_q.size() == 0)
               flag("spurious_load");
            else
               chk("d_out", int'(d_out), int'(exp_q[0]));
         end
         if (done && err) begin
            flag("done_and_err");
         end else if (done || err) begin
            if (exp_q.size() == 0) begin
               flag("unexpected_result");
            end else begin
               chk("outcome_err", int'(err), int'(exp_err_q[0]));
               chk("load_pulses", n_loads, exp_loads_q[0]);
               void'(exp_q.pop_front());
               void'(exp_err_q.pop_front());
               void'(exp_loads_q.pop_front());
               void'(fault_q.pop_front());
               if (err && err_model < 255)
                  err_model++;
            end
            n_loads = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Outcome of a preset follows from how many of its loads the counter botches.
   task automatic push(input logic [WIDTH-1:0] data, input int faults, input bit expect_full);
      int waited = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_data  = data;
      if (expect_full)
         chk("ready_when_full", int'(req_ready), 0);
      while (!req_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         flag("push_timeout");
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(data);
      exp_err_q.push_back(faults > MAX_RETRY);
      exp_loads_q.push_back(((faults > MAX_RETRY) ? MAX_RETRY : faults) + 1);
      fault_q.push_back(faults);
      #1 req_valid = 1'b0;
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_err_q.delete();
      exp_loads_q.delete();
      fault_q.delete();
      load_t_q.delete();
      n_loads   = 0;
      err_model = 0;
   endtask

   task automatic drain(input int budget);
      int waited = 0;
      while (exp_q.size() != 0 && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (exp_q.size() != 0) begin
         flag("drain_timeout");
         clear_model();
      end
      repeat (GAP_CYC + 2) @(negedge clk);
      chk("busy_idle", int'(busy), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_load", int'(load), 0);
      chk("rst_d_out", int'(d_out), 0);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err_count", int'(err_count), 0);
      rst = 1'b1;

      // basic load with latency check
      push(4'b0110, 0, 1'b0);
      @(negedge clk);
      chk("lat_t1_load", int'(load), 0);
      @(negedge clk);
      chk("lat_t2_load", int'(load), 1);
      chk("lat_t2_d_out", int'(d_out), 6);
      @(negedge clk);
      chk("lat_t3_done", int'(done), 1);
      chk("lat_t3_cnt", int'(cnt_in), 6);
      drain(100);

      // back-to-back into a two-deep FIFO
      load_t_q.delete();
      push(4'd6, 0, 1'b0);
      push(4'd14, 0, 1'b0);
      push(4'd3, 0, 1'b1);
      drain(200);
      chk("b2b_loads", load_t_q.size(), 3);
      if (load_t_q.size() == 3) begin
         chk("b2b_space0", load_t_q[1] - load_t_q[0], 3 + GAP_CYC);
         chk("b2b_space1", load_t_q[2] - load_t_q[1], 3 + GAP_CYC);
      end

      // stuck counter: abandoned after 1 + MAX_RETRY pulses
      push(4'd9, MAX_RETRY + 1, 1'b0);
      drain(200);
      chk("err_count_one", int'(err_count), 1);

      // counter recovers on the retry
      push(4'd5, 1, 1'b0);
      drain(200);
      chk("err_count_still_one", int'(err_count), 1);

      // asynchronous reset in the LOAD cycle
      push(4'd9, 0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_load", int'(load), 1);
      #1 rst = 1'b0;
      #1;
      chk("async_load", int'(load), 0);
      chk("async_d_out", int'(d_out), 0);
      chk("async_ready", int'(req_ready), 1);
      chk("async_busy", int'(busy), 0);
      chk("async_err_count", int'(err_count), 0);
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         int f;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         f = ($urandom_range(0, 3) == 0) ? $urandom_range(1, MAX_RETRY + 1) : 0;
         push(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), f, 1'b0);
      end
      drain(2000);

      // saturation
      for (int i = 0; i < 256; i++)
         push(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), MAX_RETRY + 1, 1'b0);
      drain(5000);
      chk("err_count_sat", int'(err_count), 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
